// File: rtl/median_win_ctrl.sv
// median_win_ctrl: sequencer and output stage for the 3x3 median filter.
// It tracks the raster position from valid/hs/vs and runs the frame-fill FSM.
// It delays the raw pixel, the select tag and the sync signals to match the
// filter latency, then muxes the filtered or border pixel onto a registered output.
// It also reports frame done and sticky geometry errors.
// Optional build macro: MEDIAN_BORDER_ZERO_EN. When it is defined, border pixels
// are output as 0. When it is undefined, border pixels are the raw pixel.
module median_win_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FILT_LAT   = 4,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  data_in_hs,
  input  logic                  data_in_vs,
  input  logic [DATA_WIDTH-1:0] filt_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  data_out_hs,
  output logic                  data_out_vs,
  output logic [CNT_W-1:0]      col_cnt,
  output logic [CNT_W-1:0]      row_cnt,
  output logic [1:0]            state,
  output logic                  frame_done,
  output logic                  line_err,
  output logic                  ovf_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hsDly_q, vsDly_q;
  logic hsRise, hsFall, vsRise, vsFall, pixelIn, selIn, reachRow2;

  logic [CNT_W-1:0] colCnt_q, colCnt_d, rowCnt_q, rowCnt_d;
  logic             lineErr_q, lineErr_d, ovfErr_q, ovfErr_d;
  state_e           state_q, state_d;

  logic [FILT_LAT-1:0]   selPipe_q, validPipe_q, hsPipe_q, vsPipe_q;
  logic [DATA_WIDTH-1:0] dataPipe_q [FILT_LAT];

  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d, borderPix;
  logic                  validOut_q, hsOut_q, vsOut_q;

  // The edge reference follows the live hs/vs even during reset. This keeps a
  // reset released mid-frame from producing a false vs rise, so the FSM waits
  // for the next real frame start.
  always_ff @(posedge clk) begin
    hsDly_q <= data_in_hs;
    vsDly_q <= data_in_vs;
  end

  assign hsRise    = data_in_hs & ~hsDly_q;
  assign hsFall    = ~data_in_hs & hsDly_q;
  assign vsRise    = data_in_vs & ~vsDly_q;
  assign vsFall    = ~data_in_vs & vsDly_q;
  assign pixelIn   = data_in_valid & data_in_hs & data_in_vs;
  assign selIn     = pixelIn && (rowCnt_q >= TWO) && (colCnt_q >= TWO);
  assign reachRow2 = hsFall && data_in_vs && (rowCnt_q == ONE);

  // Raster counters and the sticky error flags. An error event in the same
  // cycle as a vs rise takes priority over the clear.
  always_comb begin
    colCnt_d  = colCnt_q;
    rowCnt_d  = rowCnt_q;
    lineErr_d = lineErr_q;
    ovfErr_d  = ovfErr_q;
    if (hsFall) begin
      colCnt_d = '0;
    end else if (pixelIn && (colCnt_q < IMG_W_C)) begin
      colCnt_d = colCnt_q + ONE;
    end
    if (vsRise) begin
      rowCnt_d = '0;
    end else if (hsFall && data_in_vs && (rowCnt_q != CNT_MAX)) begin
      rowCnt_d = rowCnt_q + ONE;
    end
    if (hsFall && (colCnt_q != IMG_W_C)) begin
      lineErr_d = 1'b1;
    end else if (vsRise) begin
      lineErr_d = 1'b0;
    end
    if ((pixelIn && (colCnt_q >= IMG_W_C)) || (hsRise && (rowCnt_q >= IMG_H_C))) begin
      ovfErr_d = 1'b1;
    end else if (vsRise) begin
      ovfErr_d = 1'b0;
    end
  end

  // Frame-fill FSM next state. A vs rise restarts filling from any state.
  always_comb begin
    state_d = state_q;
    if (vsRise) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FILL: begin
          if (vsFall)         state_d = DONE;
          else if (reachRow2) state_d = RUN;
        end
        RUN:     if (vsFall) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Border pixels are either the raw pixel or zero, depending on the build.
  always_comb begin
`ifdef MEDIAN_BORDER_ZERO_EN
    borderPix = '0;
`else
    borderPix = dataPipe_q[FILT_LAT-1];
`endif
  end

  // The output mux uses the delayed tag to pick the filtered or border pixel.
  // Gaps are output as 0.
  always_comb begin
    dataOut_d = '0;
    if (validPipe_q[FILT_LAT-1]) begin
      dataOut_d = selPipe_q[FILT_LAT-1] ? filt_data : borderPix;
    end
  end

  // All state registers, the free-running delay lines and the output stage.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      colCnt_q    <= '0;
      rowCnt_q    <= '0;
      lineErr_q   <= 1'b0;
      ovfErr_q    <= 1'b0;
      state_q     <= IDLE;
      selPipe_q   <= '0;
      validPipe_q <= '0;
      hsPipe_q    <= '0;
      vsPipe_q    <= '0;
      for (int i = 0; i < FILT_LAT; i++) dataPipe_q[i] <= '0;
      dataOut_q   <= '0;
      validOut_q  <= 1'b0;
      hsOut_q     <= 1'b0;
      vsOut_q     <= 1'b0;
    end else begin
      colCnt_q       <= colCnt_d;
      rowCnt_q       <= rowCnt_d;
      lineErr_q      <= lineErr_d;
      ovfErr_q       <= ovfErr_d;
      state_q        <= state_d;
      selPipe_q[0]   <= selIn;
      validPipe_q[0] <= data_in_valid;
      hsPipe_q[0]    <= data_in_hs;
      vsPipe_q[0]    <= data_in_vs;
      dataPipe_q[0]  <= data_in;
      for (int i = 1; i < FILT_LAT; i++) begin
        selPipe_q[i]   <= selPipe_q[i-1];
        validPipe_q[i] <= validPipe_q[i-1];
        hsPipe_q[i]    <= hsPipe_q[i-1];
        vsPipe_q[i]    <= vsPipe_q[i-1];
        dataPipe_q[i]  <= dataPipe_q[i-1];
      end
      dataOut_q  <= dataOut_d;
      validOut_q <= validPipe_q[FILT_LAT-1];
      hsOut_q    <= hsPipe_q[FILT_LAT-1];
      vsOut_q    <= vsPipe_q[FILT_LAT-1];
    end
  end

  assign data_out       = dataOut_q;
  assign data_out_valid = validOut_q;
  assign data_out_hs    = hsOut_q;
  assign data_out_vs    = vsOut_q;
  assign col_cnt        = colCnt_q;
  assign row_cnt        = rowCnt_q;
  assign state          = state_q;
  assign frame_done     = (state_q == DONE);
  assign line_err       = lineErr_q;
  assign ovf_err        = ovfErr_q;

endmodule

// File: tb/tb_median_win_ctrl.sv
// tb_median_win_ctrl: randomized frames driven into median_win_ctrl.
// The outputs are compared every cycle against a behavioural raster model.
// The model keeps its input history in arrays and derives each output from
// the input that was sampled FILT_LAT+1 cycles earlier.
module tb_median_win_ctrl;
  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int L    = 4;
  localparam int CW   = 4;
  localparam int HMAX = 8192;
  localparam int S_IDLE = 0, S_FILL = 1, S_RUN = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          reset_p = 1'b0;
  logic [DW-1:0] data_in = '0, filt_data = '0;
  logic          data_in_valid = 1'b0, data_in_hs = 1'b0, data_in_vs = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_out_valid, data_out_hs, data_out_vs;
  logic [CW-1:0] col_cnt, row_cnt;
  logic [1:0]    state;
  logic          frame_done, line_err, ovf_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int donePulses = 0;

  logic [DW-1:0] dHist [HMAX];
  logic [DW-1:0] fHist [HMAX];
  bit            vHist [HMAX];
  bit            hHist [HMAX];
  bit            sHist [HMAX];
  bit            selHist [HMAX];

  int mCol = 0, mRow = 0, mSt = S_IDLE, lastReset = 0;
  bit mLineErr = 0, mOvfErr = 0, pHs = 0, pVs = 0;

  median_win_ctrl #(
    .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .FILT_LAT(L), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_p(reset_p), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_hs(data_in_hs), .data_in_vs(data_in_vs),
    .filt_data(filt_data), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_hs(data_out_hs), .data_out_vs(data_out_vs), .col_cnt(col_cnt),
    .row_cnt(row_cnt), .state(state), .frame_done(frame_done),
    .line_err(line_err), .ovf_err(ovf_err)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Drive one cycle. Compare outputs at the falling edge, then advance the model.
  task automatic stepCycle(input bit rst, input bit v, input bit h, input bit s);
    int m;
    bit hr, hf, vr, vf, pix;
    logic [31:0] expData;
    reset_p       = rst;
    data_in_valid = v;
    data_in_hs    = h;
    data_in_vs    = s;
    data_in       = DW'($urandom);
    filt_data     = DW'($urandom);
    if (cyc < HMAX) begin
      dHist[cyc]   = data_in;
      fHist[cyc]   = filt_data;
      vHist[cyc]   = v;
      hHist[cyc]   = h;
      sHist[cyc]   = s;
      selHist[cyc] = v && h && s && (mRow >= 2) && (mCol >= 2);
    end
    @(negedge clk);
    if (frame_done === 1'b1) donePulses++;
    if (cyc > 0 && cyc < HMAX) begin
      checkOutput("col_cnt", 32'(col_cnt), mCol);
      checkOutput("row_cnt", 32'(row_cnt), mRow);
      checkOutput("state", 32'(state), mSt);
      checkOutput("frame_done", 32'(frame_done), (mSt == S_DONE) ? 1 : 0);
      checkOutput("line_err", 32'(line_err), 32'(mLineErr));
      checkOutput("ovf_err", 32'(ovf_err), 32'(mOvfErr));
      m = cyc - (L + 1);
      if (m <= lastReset) begin
        checkOutput("data_out", 32'(data_out), 0);
        checkOutput("out_valid", 32'(data_out_valid), 0);
        checkOutput("out_hs", 32'(data_out_hs), 0);
        checkOutput("out_vs", 32'(data_out_vs), 0);
      end else begin
        expData = 0;
        if (vHist[m]) begin
`ifdef MEDIAN_BORDER_ZERO_EN
          expData = selHist[m] ? 32'(fHist[cyc-1]) : 0;
`else
          expData = selHist[m] ? 32'(fHist[cyc-1]) : 32'(dHist[m]);
`endif
        end
        checkOutput("data_out", 32'(data_out), expData);
        checkOutput("out_valid", 32'(data_out_valid), 32'(vHist[m]));
        checkOutput("out_hs", 32'(data_out_hs), 32'(hHist[m]));
        checkOutput("out_vs", 32'(data_out_vs), 32'(sHist[m]));
      end
    end
    if (rst) begin
      mCol = 0; mRow = 0; mSt = S_IDLE; mLineErr = 0; mOvfErr = 0;
      lastReset = cyc;
    end else begin
      hr  = h && !pHs;
      hf  = !h && pHs;
      vr  = s && !pVs;
      vf  = !s && pVs;
      pix = v && h && s;
      if (hf && mCol != W) mLineErr = 1;
      else if (vr)         mLineErr = 0;
      if ((pix && mCol >= W) || (hr && mRow >= H)) mOvfErr = 1;
      else if (vr)                                 mOvfErr = 0;
      if (vr) mSt = S_FILL;
      else if (mSt == S_FILL && vf) mSt = S_DONE;
      else if (mSt == S_FILL && hf && s && mRow == 1) mSt = S_RUN;
      else if (mSt == S_RUN && vf) mSt = S_DONE;
      else if (mSt == S_DONE) mSt = S_IDLE;
      if (hf) mCol = 0;
      else if (pix) mCol = (mCol + 1 > W) ? W : mCol + 1;
      if (vr) mRow = 0;
      else if (hf && s) mRow = (mRow + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mRow + 1;
    end
    pHs = h;
    pVs = s;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One frame. Optional short or long line, an optional mid-line reset, and a vertical blank.
  task automatic applyStimulus(input int nLines, input int shortLine, input int longLine,
                               input int resetLine, input int gapMax, input int blank);
    int np, g, lead, hgap;
    lead = $urandom_range(1, 2);
    repeat (lead) stepCycle(0, 0, 0, 1);
    for (int ln = 0; ln < nLines; ln++) begin
      np = W;
      if (ln == shortLine) np = W - 1;
      if (ln == longLine)  np = W + 1;
      for (int p = 0; p < np; p++) begin
        g = $urandom_range(0, gapMax);
        repeat (g) stepCycle(0, 0, 1, 1);
        stepCycle(0, 1, 1, 1);
        if (ln == resetLine && p == 1) stepCycle(1, 0, 1, 1);
      end
      hgap = $urandom_range(1, 2);
      repeat (hgap) stepCycle(0, 0, 0, 1);
    end
    repeat (blank) stepCycle(0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    repeat (3) stepCycle(1, 0, 0, 0);
    checkOutput("rstState", 32'(state), S_IDLE);
    checkOutput("rstDataOut", 32'(data_out), 0);
    repeat (2) stepCycle(0, 0, 0, 0);

    donePulses = 0;
    applyStimulus(4, -1, -1, -1, 0, 3);
    checkOutput("frameDoneOnce", donePulses, 1);

    applyStimulus(4, 1, -1, -1, 1, 2);
    checkOutput("lineErrSticky", 32'(line_err), 1);

    applyStimulus(5, -1, 2, -1, 1, 2);
    checkOutput("ovfSticky", 32'(ovf_err), 1);

    donePulses = 0;
    applyStimulus(4, -1, -1, 2, 1, 3);
    checkOutput("noDoneAfterReset", donePulses, 0);

    for (int f = 0; f < 6; f++) begin
      applyStimulus(4, -1, -1, -1, 2, $urandom_range(1, 3));
    end
    repeat (10) stepCycle(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
